// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// pipe_ctrl_pkg : shared state encodings and widths for the pipeline controller
// Revision      : 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned WAIT_W = 8;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [1:0] {
    PC_RUN     = 2'b00,
    PC_MEMWAIT = 2'b01,
    PC_HALT    = 2'b11
  } pc_state_t;

  // Last wait_cnt value tolerated in MEMWAIT before the core is halted.
  function automatic logic [WAIT_W-1:0] wait_limit(input int unsigned max_wait);
    return WAIT_W'(max_wait - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_det.sv
// ============================================================================
// pipe_hazard_det : combinational load-use hazard detection for the ID stage
// Revision        : 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_det
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             idex_memread,
  output logic             load_use
);

  logic rs_match;
  logic rt_match;

  // $zero never carries a dependency, so a load targeting it is harmless.
  assign rs_match = (idex_rt == ifid_rs);
  assign rt_match = ifid_uses_rt & (idex_rt == ifid_rt);
  assign load_use = idex_memread & (idex_rt != '0) & (rs_match | rt_match);

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : ID-stage sequencing (advance / load-use stall / memory freeze /
//             branch flush) with bounded memory wait. Optional perf counters
//             are built when PIPE_CTRL_PERF_EN is defined.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             idex_memread,
  input  logic             exmem_memread,
  input  logic             exmem_memwrite,
  input  logic             exmem_pcsrc,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             freeze,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = wait_limit(MAX_WAIT);

  pc_state_t         state;
  pc_state_t         state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              load_use;
  logic              mem_busy;
  logic              mem_freeze;

  pipe_hazard_det u_hazard (
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_uses_rt (ifid_uses_rt),
    .idex_rt      (idex_rt),
    .idex_memread (idex_memread),
    .load_use     (load_use)
  );

  assign mem_busy = (exmem_memread | exmem_memwrite) & ~dmem_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= PC_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    freeze      = 1'b0;
    mem_freeze  = 1'b0;

    case (state)
      PC_RUN: begin
        mem_freeze = mem_busy;
        if (mem_busy) begin
          state_nxt = PC_MEMWAIT;
          wait_nxt  = WAIT_W'(1);
        end
      end
      PC_MEMWAIT: begin
        mem_freeze = ~dmem_ready;
        if (dmem_ready) begin
          state_nxt = PC_RUN;
          wait_nxt  = '0;
        end else if (wait_cnt >= WAIT_LIMIT) begin
          state_nxt = PC_HALT;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      PC_HALT: begin
        mem_freeze = 1'b1;
      end
      default: begin
        mem_freeze = 1'b1;
        state_nxt  = PC_RUN;
        wait_nxt   = '0;
      end
    endcase

    // Reset forces a full hold regardless of what the pipeline presents.
    if (!reset || mem_freeze) begin
      freeze = 1'b1;
    end else if (exmem_pcsrc) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      idex_bubble = 1'b1;
    end else begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
    end
  end

  assign halted = reset & (state == PC_HALT);

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (freeze || idex_bubble) stall_cnt <= stall_cnt + CNT_W'(1);
      if (exmem_flush)           flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// tb_pipe_ctrl : directed checks of pipe_ctrl (MAX_WAIT=16 and MAX_WAIT=4)
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Output vector: {pc_write, ifid_write, idex_bubble, ifid_flush,
  //                 idex_flush, exmem_flush, freeze, halted}
  localparam logic [7:0] V_ADV   = 8'b1100_0000;
  localparam logic [7:0] V_STALL = 8'b0010_0000;
  localparam logic [7:0] V_FLUSH = 8'b1101_1100;
  localparam logic [7:0] V_FRZ   = 8'b0000_0010;
  localparam logic [7:0] V_HALT  = 8'b0000_0011;
  localparam logic [7:0] V_RST   = 8'b0000_0010;

  logic       clock;
  logic       reset;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic       ifid_uses_rt, idex_memread;
  logic       exmem_memread, exmem_memwrite, exmem_pcsrc, dmem_ready;

  logic        a_pcw, a_ifw, a_bub, a_iff, a_idf, a_exf, a_frz, a_hlt;
  logic        b_pcw, b_ifw, b_bub, b_iff, b_idf, b_exf, b_frz, b_hlt;
  logic [31:0] a_stall, a_flush, b_stall, b_flush;
  logic [7:0]  out16, out4;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] exp_stall = 0;
  logic [31:0] exp_flush = 0;

  assign out16 = {a_pcw, a_ifw, a_bub, a_iff, a_idf, a_exf, a_frz, a_hlt};
  assign out4  = {b_pcw, b_ifw, b_bub, b_iff, b_idf, b_exf, b_frz, b_hlt};

  pipe_ctrl dut (
    .clock(clock), .reset(reset),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_rt(idex_rt), .idex_memread(idex_memread),
    .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
    .exmem_pcsrc(exmem_pcsrc), .dmem_ready(dmem_ready),
    .pc_write(a_pcw), .ifid_write(a_ifw), .idex_bubble(a_bub),
    .ifid_flush(a_iff), .idex_flush(a_idf), .exmem_flush(a_exf),
    .freeze(a_frz), .halted(a_hlt), .stall_cnt(a_stall), .flush_cnt(a_flush)
  );

  pipe_ctrl #(.MAX_WAIT(4)) dut4 (
    .clock(clock), .reset(reset),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_rt(idex_rt), .idex_memread(idex_memread),
    .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
    .exmem_pcsrc(exmem_pcsrc), .dmem_ready(dmem_ready),
    .pc_write(b_pcw), .ifid_write(b_ifw), .idex_bubble(b_bub),
    .ifid_flush(b_iff), .idex_flush(b_idf), .exmem_flush(b_exf),
    .freeze(b_frz), .halted(b_hlt), .stall_cnt(b_stall), .flush_cnt(b_flush)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b0;
    idex_rt = 5'd0; idex_memread = 1'b0;
    exmem_memread = 1'b0; exmem_memwrite = 1'b0;
    exmem_pcsrc = 1'b0; dmem_ready = 1'b1;
  endtask

  // Called at a falling edge with inputs already applied: check outputs,
  // cross the rising edge, update the counter model, return at the next fall.
  task automatic cyc(input string tag, input logic [7:0] e16, input logic [7:0] e4);
    #1;
    chk({tag, ".o16"}, {24'd0, out16}, {24'd0, e16});
    chk({tag, ".o4"},  {24'd0, out4},  {24'd0, e4});
    @(posedge clock);
    if (PERF && (e16[1] || e16[5])) exp_stall = exp_stall + 1;
    if (PERF && e16[2])             exp_flush = exp_flush + 1;
    @(negedge clock);
  endtask

  task automatic chk_cnt(input string tag);
    #1;
    chk({tag, ".stall"}, a_stall, exp_stall);
    chk({tag, ".flush"}, a_flush, exp_flush);
  endtask

  initial begin
    idle();
    reset = 1'b0;
    // Busy memory and taken branch during reset must not leak to outputs.
    exmem_memread = 1'b1; dmem_ready = 1'b0; exmem_pcsrc = 1'b1;
    @(negedge clock);
    #1;
    chk("reset.o16", {24'd0, out16}, {24'd0, V_RST});
    chk("reset.o4",  {24'd0, out4},  {24'd0, V_RST});
    chk_cnt("reset");
    @(negedge clock);
    idle();
    reset = 1'b1;
    cyc("first", V_ADV, V_ADV);

    // Load-use: LW $2 in EX, ADD $3,$2,$4 in ID
    idex_memread = 1'b1; idex_rt = 5'd2; ifid_rs = 5'd2; ifid_rt = 5'd4; ifid_uses_rt = 1'b1;
    cyc("lu.stall", V_STALL, V_STALL);
    idex_memread = 1'b0; exmem_memread = 1'b1; dmem_ready = 1'b1;
    cyc("lu.after", V_ADV, V_ADV);
    chk_cnt("lu");

    // No hazard on $zero, nor on rt when rt is not read
    idle();
    idex_memread = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b1;
    cyc("lu.zero", V_ADV, V_ADV);
    idex_rt = 5'd2; ifid_rs = 5'd5; ifid_rt = 5'd2; ifid_uses_rt = 1'b0;
    cyc("lu.rt_unused", V_ADV, V_ADV);
    ifid_uses_rt = 1'b1;
    cyc("lu.rt_used", V_STALL, V_STALL);

    // Taken branch overrides the pending load-use
    exmem_pcsrc = 1'b1;
    cyc("br.flush", V_FLUSH, V_FLUSH);
    idle();
    cyc("br.after", V_ADV, V_ADV);
    chk_cnt("br");

    // Access ready in its first MEM cycle: no freeze
    exmem_memread = 1'b1; dmem_ready = 1'b1;
    cyc("mem.fast", V_ADV, V_ADV);

    // Three not-ready cycles, load-use presented meanwhile must be ignored
    dmem_ready = 1'b0;
    cyc("mem.w1", V_FRZ, V_FRZ);
    idex_memread = 1'b1; idex_rt = 5'd7; ifid_rs = 5'd7;
    cyc("mem.w2", V_FRZ, V_FRZ);
    exmem_pcsrc = 1'b1;
    cyc("mem.w3", V_FRZ, V_FRZ);
    // Ready together with a taken branch in MEMWAIT: flush this cycle
    dmem_ready = 1'b1;
    cyc("mem.rdy_br", V_FLUSH, V_FLUSH);
    idle();
    cyc("mem.after", V_ADV, V_ADV);
    chk_cnt("mem");

    // Timeout: dut4 halts after 4 not-ready cycles, dut after 16
    exmem_memwrite = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      cyc($sformatf("to.c%0d", i), (i <= 16) ? V_FRZ : V_HALT, (i <= 4) ? V_FRZ : V_HALT);
    end
    idle();
    cyc("to.sticky", V_HALT, V_HALT);
    chk_cnt("to");

    // Reset pulse out of HALT
    reset = 1'b0;
    #1;
    chk("rst_halt.o16", {24'd0, out16}, {24'd0, V_RST});
    chk("rst_halt.o4",  {24'd0, out4},  {24'd0, V_RST});
    exp_stall = 0; exp_flush = 0;
    chk_cnt("rst_halt");
    @(negedge clock);
    reset = 1'b1;
    cyc("rst_halt.run", V_ADV, V_ADV);

    // Async reset between edges while in MEMWAIT
    exmem_memread = 1'b1; dmem_ready = 1'b0;
    cyc("ar.w1", V_FRZ, V_FRZ);
    dmem_ready = 1'b1; exmem_pcsrc = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("ar.o16", {24'd0, out16}, {24'd0, V_RST});
    chk("ar.o4",  {24'd0, out4},  {24'd0, V_RST});
    exp_stall = 0; exp_flush = 0;
    chk_cnt("ar");
    @(negedge clock);
    idle();
    reset = 1'b1;
    cyc("ar.run", V_ADV, V_ADV);
    // A fresh wait after reset must again survive 3 cycles on dut4
    exmem_memread = 1'b1; dmem_ready = 1'b0;
    cyc("ar.m1", V_FRZ, V_FRZ);
    cyc("ar.m2", V_FRZ, V_FRZ);
    cyc("ar.m3", V_FRZ, V_FRZ);
    dmem_ready = 1'b1;
    cyc("ar.m4", V_ADV, V_ADV);
    chk_cnt("ar.end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
